// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the bit-slice counter for a given operand width (at least 1 bit).
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full adder, used as the shared bit-slice datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full_adder time-shared over WIDTH bit
// slices, LSB first. Operands come in over a valid/ready handshake and the
// sum plus carry-out leave over a second valid/ready handshake.
// Optional macro SERIAL_ADDER_OVF_EN adds ovf_o (signed two's-complement
// overflow of the last result).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready_o is high only in IDLE; out_valid_o is high only in
// DONE and stays high until out_ready_i is seen; the producer must hold its
// data stable while valid is high and not yet accepted.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  // a_sh doubles as the sum shift register: each RUN edge consumes bit 0
  // of A and inserts the new sum bit at the MSB, so after WIDTH edges it
  // holds the complete sum.
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] a_shifted;

  full_adder u_fa (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_cout)
  );

  // New sum bit enters at the MSB while A shifts out at the LSB.
  if (WIDTH == 1) begin : g_shift_w1
    assign a_shifted = fa_sum;
  end else begin : g_shift_wn
    assign a_shifted = {fa_sum, a_sh_q[WIDTH-1:1]};
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath sequencing: capture, shift per bit, publish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_shifted;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = a_shifted;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this final slice.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == RUN);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: three instances (WIDTH 8, 3 and 1) driven by
// directed vectors, checked every cycle against an arithmetic model, plus
// literal expectations. Optional macro SERIAL_ADDER_OVF_EN adds ovf_o checks.
module tb_serial_adder_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- DUT signals ----------------
  logic       iv8 = 0, ir8, c8 = 0, ov8, or8 = 0, co8, bz8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic       iv3 = 0, ir3, c3 = 0, ov3, or3 = 1, co3, bz3;
  logic [2:0] a3 = 0, b3 = 0, s3;
  logic       iv1 = 0, ir1, c1 = 0, ov1, or1 = 1, co1, bz1;
  logic [0:0] a1 = 0, b1 = 0, s1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       of8, of3, of1;
`endif

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ir8),
    .a_i(a8), .b_i(b8), .cin_i(c8), .out_valid_o(ov8), .out_ready_i(or8),
    .sum_o(s8), .cout_o(co8), .busy_o(bz8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(of8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv3), .in_ready_o(ir3),
    .a_i(a3), .b_i(b3), .cin_i(c3), .out_valid_o(ov3), .out_ready_i(or3),
    .sum_o(s3), .cout_o(co3), .busy_o(bz3)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(of3)
`endif
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(ir1),
    .a_i(a1), .b_i(b1), .cin_i(c1), .out_valid_o(ov1), .out_ready_i(or1),
    .sum_o(s1), .cout_o(co1), .busy_o(bz1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(of1)
`endif
  );

  // ---------------- checker ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An operation is a countdown of WIDTH busy edges, then a result held until
  // taken; the result is plain a+b+cin.
  typedef struct {
    int         run_left;
    bit         done;
    logic [64:0] res;
    logic [64:0] pend;
    bit         ovf;
    bit         povf;
  } m_t;

  function automatic m_t step(m_t m, logic r, logic iv, logic [63:0] a, logic [63:0] b,
                              logic c, logic ordy, int w);
    m_t n = m;
    if (r) begin
      n.run_left = 0; n.done = 0; n.res = '0; n.ovf = 0;
    end else if (m.run_left > 0) begin
      n.run_left = m.run_left - 1;
      if (n.run_left == 0) begin
        n.done = 1; n.res = m.pend; n.ovf = m.povf;
      end
    end else if (m.done) begin
      if (ordy) n.done = 0;
    end else if (iv) begin
      n.run_left = w;
      n.pend = 65'(a) + 65'(b) + 65'(c);
      n.povf = (a[w-1] == b[w-1]) && (n.pend[w-1] != a[w-1]);
    end
    return n;
  endfunction

  m_t m8 = '{0, 1'b0, 65'd0, 65'd0, 1'b0, 1'b0};
  m_t m3 = '{0, 1'b0, 65'd0, 65'd0, 1'b0, 1'b0};
  m_t m1 = '{0, 1'b0, 65'd0, 65'd0, 1'b0, 1'b0};

  // Compare process: advance the model on each edge, check just after it.
  always @(posedge clk) begin
    m8 = step(m8, rst, iv8, 64'(a8), 64'(b8), c8, or8, 8);
    m3 = step(m3, rst, iv3, 64'(a3), 64'(b3), c3, or3, 3);
    m1 = step(m1, rst, iv1, 64'(a1), 64'(b1), c1, or1, 1);
    #1;
    chk("d8_in_ready",  ir8, (m8.run_left == 0) && !m8.done);
    chk("d8_busy",      bz8, m8.run_left > 0);
    chk("d8_out_valid", ov8, m8.done);
    chk("d8_result",    {co8, s8}, m8.res[8:0]);
    chk("d3_in_ready",  ir3, (m3.run_left == 0) && !m3.done);
    chk("d3_busy",      bz3, m3.run_left > 0);
    chk("d3_out_valid", ov3, m3.done);
    chk("d3_result",    {co3, s3}, m3.res[3:0]);
    chk("d1_in_ready",  ir1, (m1.run_left == 0) && !m1.done);
    chk("d1_busy",      bz1, m1.run_left > 0);
    chk("d1_out_valid", ov1, m1.done);
    chk("d1_result",    {co1, s1}, m1.res[1:0]);
`ifdef SERIAL_ADDER_OVF_EN
    chk("d8_ovf", of8, m8.ovf);
    chk("d3_ovf", of3, m3.ovf);
    chk("d1_ovf", of1, m1.ovf);
`endif
  end

  // ---------------- driver tasks ----------------
  function automatic logic rdy(input int sel);
    case (sel)
      8: return ir8;
      3: return ir3;
      default: return ir1;
    endcase
  endfunction

  function automatic logic vld(input int sel);
    case (sel)
      8: return ov8;
      3: return ov3;
      default: return ov1;
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    case (sel)
      8: begin iv8 = v; a8 = a; b8 = b; c8 = c; end
      3: begin iv3 = v; a3 = a[2:0]; b3 = b[2:0]; c3 = c; end
      default: begin iv1 = v; a1 = a[0]; b1 = b[0]; c1 = c; end
    endcase
  endtask

  // Present one operand pair; returns at the falling edge after acceptance.
  task automatic send(input int sel, input logic [7:0] a, input logic [7:0] b, input logic c);
    int n = 0;
    @(negedge clk);
    while (!rdy(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 1'b1, 1'b0);
    drive(sel, 1'b1, a, b, c);
    @(negedge clk);
    acc_cyc = cyc_n;
    drive(sel, 1'b0, a, b, c);
  endtask

  // Count falling edges until out_valid_o rises (bounded).
  task automatic wait_valid(input int sel, output int cyc);
    cyc = 0;
    while (!vld(sel) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) chk("valid_timeout", 1'b1, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    int prev;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", ir8, 1'b1);
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_busy", bz8, 1'b0);
    chk("rst_sum_cout", {co8, s8}, 9'h000);

    // Abort mid-RUN: no result ever appears
    send(8, 8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov8) seen = 1;
    end
    chk("abort_no_valid", seen, 1'b0);
    chk("abort_in_ready", ir8, 1'b1);
    chk("abort_sum_cout", {co8, s8}, 9'h000);

    // Basic add, latency, then backpressure in DONE
    or8 = 1'b0;
    send(8, 8'h35, 8'h4A, 1'b0);
    wait_valid(8, lat);
    chk("basic_latency", lat, 8);
    chk("basic_sum", s8, 8'h7F);
    chk("basic_cout", co8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(8, 1'b1, 8'h01, 8'h01, 1'b0);
      @(negedge clk);
      chk("bp_valid", ov8, 1'b1);
      chk("bp_sum", {co8, s8}, 9'h07F);
      chk("bp_in_ready", ir8, 1'b0);
    end
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    or8 = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", ov8, 1'b0);
    chk("bp_release_ready", ir8, 1'b1);
    chk("bp_hold_sum", s8, 8'h7F);

    // Carry chain and other 8-bit vectors
    send(8, 8'hFF, 8'h00, 1'b1);
    wait_valid(8, lat);
    chk("wrap_result", {co8, s8}, 9'h100);
    send(8, 8'h7F, 8'h01, 1'b0);
    wait_valid(8, lat);
    chk("ovf_case_result", {co8, s8}, 9'h080);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_case_flag", of8, 1'b1);
`endif
    send(8, 8'hC8, 8'h64, 1'b0);
    wait_valid(8, lat);
    chk("c8_64_result", {co8, s8}, 9'h12C);
    send(8, 8'h80, 8'h80, 1'b0);
    wait_valid(8, lat);
    chk("80_80_result", {co8, s8}, 9'h100);
`ifdef SERIAL_ADDER_OVF_EN
    chk("80_80_ovf", of8, 1'b1);
`endif
    send(8, 8'hA5, 8'h5A, 1'b1);
    wait_valid(8, lat);
    chk("a5_5a_result", {co8, s8}, 9'h100);

    // Exhaustive WIDTH=3, back-to-back
    prev = 0;
    for (int i = 0; i < 128; i++) begin
      send(3, 8'(i & 7), 8'((i >> 3) & 7), 1'((i >> 6) & 1));
      if (i > 0) chk("d3_spacing", acc_cyc - prev, 5);
      prev = acc_cyc;
    end
    wait_valid(3, lat);
    chk("d3_last_result", {co3, s3}, 4'hF);

    // WIDTH=1 corner
    send(1, 8'h01, 8'h01, 1'b1);
    wait_valid(1, lat);
    chk("d1_latency", lat, 1);
    chk("d1_result_111", {co1, s1}, 2'b11);
    send(1, 8'h00, 8'h01, 1'b0);
    wait_valid(1, lat);
    chk("d1_result_010", {co1, s1}, 2'b01);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add controller that time-shares a single `full_adder` instance across WIDTH-bit operands, one bit per clock, LSB first. It accepts an operand pair over a valid/ready handshake and sequences the full adder through WIDTH bit slices. It returns the WIDTH-bit sum plus carry-out over a second valid/ready handshake. It sits between a requester and the 1-bit adder datapath, as the area-minimal alternative to a ripple array.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, asynchronous, active-high reset.
- in_valid_i, input, 1, operand pair valid.
- in_ready_o, output, 1, controller can accept operands.
- a_i, input, WIDTH, operand A.
- b_i, input, WIDTH, operand B.
- cin_i, input, 1, carry-in for bit 0.
- out_valid_o, output, 1, result valid.
- out_ready_i, input, 1, consumer accepts result.
- sum_o, output, WIDTH, sum result.
- cout_o, output, 1, carry-out of MSB.
- busy_o, output, 1, high while in RUN.

Behaviour:
- Reset (async, rst_i=1), all registers cleared:
  - state=IDLE, cnt=0, carry=0, sum_o=0, cout_o=0.
  - out_valid_o=0, busy_o=0.
  - in_ready_o=1 as soon as reset deasserts.
- FSM states are IDLE, RUN and DONE.
  - IDLE: in_ready_o=1. On an edge with in_valid_i=1:
    - latch a_i and b_i into shift registers and cin_i into carry;
    - set cnt=0 and go to RUN.
  - RUN: busy_o=1, in_ready_o=0. Each edge:
    - full_adder inputs are a_sh[0], b_sh[0], carry;
    - its sum bit shifts into sum register MSB (sum register shifts right) and its cout loads carry;
    - a_sh and b_sh shift right; cnt increments.
    - On the edge where cnt==WIDTH-1, go to DONE and load cout_o with the final carry.
  - DONE: out_valid_o=1, sum_o and cout_o stable. On an edge with out_ready_i=1, go to IDLE.
- Latency: accept on edge k → out_valid_o high after edge k+WIDTH.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no overlap; in_ready_o is low in RUN and DONE.
- in_valid_i while not in IDLE is ignored; operands are not captured.
- out_valid_o stays asserted until accepted. out_ready_i outside DONE is ignored.
- sum_o and cout_o hold the last result in IDLE until the next completion. sum_o is not updated mid-RUN; an internal shift register drives it on entry to DONE.
- WIDTH=1: RUN lasts exactly one edge.
- rst_i asserted mid-RUN or in DONE aborts the operation: no result and no out_valid_o pulse.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry reported on cout_o. Result equals a+b+cin as a WIDTH+1 bit value {cout_o,sum_o}.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined: adds output ovf_o (1 bit) = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow.
  - Captured on the final RUN edge; valid with out_valid_o; reset 0; held in IDLE like sum_o.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_adder_pkg holds:
  - state_t enum (IDLE, RUN, DONE), 2 bits;
  - function cnt_w(WIDTH) returning $clog2 width, with minimum 1.
- Sub-module: the existing `full_adder` (ports a_i, b_i, cin_i, sum_o, cout_o), instantiated once as the combinational bit-slice.
- FSM, counter and shift registers live in serial_adder_ctrl.

Test Plan:
- Reset behaviour: assert rst_i mid-RUN with a=8'hFF, b=8'h01, then release → out_valid_o never rises; in_ready_o=1, sum_o=0, cout_o=0 after release.
- Basic add: WIDTH=8, a=8'h35, b=8'h4A, cin=0 → out_valid_o after exactly 8 cycles, sum_o=8'h7F, cout_o=0; busy_o high for 8 cycles.
- Carry chain and wrap: a=8'hFF, b=8'h00, cin=1 → sum_o=8'h00, cout_o=1. With OVF_EN, a=8'h7F, b=8'h01, cin=0 → sum_o=8'h80, ovf_o=1.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE → out_valid_o, sum_o and cout_o stable. A new in_valid_i with a=8'h01 is ignored, in_ready_o=0. Raising out_ready_i returns to IDLE.
- Exhaustive small width: WIDTH=3, all 128 (a,b,cin) combinations back-to-back with out_ready_i=1 → {cout_o,sum_o}==a+b+cin for each; spacing of 5 cycles per op.
- WIDTH=1 corner: a=1, b=1, cin=1 → sum_o=1, cout_o=1, valid one cycle after accept.
